// File: rtl/vga_timing_if.sv
// Bundle of VGA raster timing outputs: the generator drives it through the
// master modport, while displays and pixel pipelines read it through the slave modport.
interface vga_timing_if;
  logic       vga_clk_enable;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       hbright;
  logic       vbright;
  logic       bright;
  logic       frame_start;
  logic       line_start;

  modport master (
    output vga_clk_enable, hcount, vcount, hsync, vsync,
           hbright, vbright, bright, frame_start, line_start
  );

  modport slave (
    input  vga_clk_enable, hcount, vcount, hsync, vsync,
           hbright, vbright, bright, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a half-rate pixel strobe drives the column and line
// counters, and the sync, blanking and start strobes are registered from the next counter values.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 29
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       en_q, en_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hbright_q, hbright_d;
  logic       vbright_q, vbright_d;
  logic       bright_q, bright_d;
  logic       frame_start_q, frame_start_d;
  logic       line_start_q, line_start_d;

  always_comb begin
    en_d     = ~en_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;

    // ">=" rather than "==" so an out-of-range count recovers on the next advance.
    if (en_q) begin
      if (hcount_q >= H_LAST) begin
        hcount_d = '0;
        if (vcount_q >= V_LAST) begin
          vcount_d = '0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
        if (vcount_q > V_LAST) begin
          vcount_d = '0;
        end
      end
    end

    // Decoding the next counts keeps these flops aligned with the counters.
    hsync_d       = !((hcount_d >= H_SYNC_FIRST) && (hcount_d <= H_SYNC_LAST));
    vsync_d       = !((vcount_d >= V_SYNC_FIRST) && (vcount_d <= V_SYNC_LAST));
    hbright_d     = (hcount_d < H_VIS_END);
    vbright_d     = (vcount_d < V_VIS_END);
    bright_d      = hbright_d && vbright_d;
    line_start_d  = en_q && (hcount_d == 10'd0);
    frame_start_d = line_start_d && (vcount_d == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q          <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      hbright_q     <= 1'b1;
      vbright_q     <= 1'b1;
      bright_q      <= 1'b1;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      en_q          <= en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hbright_q     <= hbright_d;
      vbright_q     <= vbright_d;
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign vga.vga_clk_enable = en_q;
  assign vga.hcount         = hcount_q;
  assign vga.vcount         = vcount_q;
  assign vga.hsync          = hsync_q;
  assign vga.vsync          = vsync_q;
  assign vga.hbright        = hbright_q;
  assign vga.vbright        = vbright_q;
  assign vga.bright         = bright_q;
  assign vga.frame_start    = frame_start_q;
  assign vga.line_start     = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a tiny-raster instance so whole
// frames fit in a short run, both checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int SH_V = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_V = 5, SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_V + SV_F + SV_S + SV_B;

  typedef struct packed {
    logic       en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
    logic       b;
    logic       fs;
    logic       ls;
  } vga_t;

  logic clk = 1'b0;
  logic rst;

  vga_timing_if big_if ();
  vga_timing_if small_if ();

  vga_timing_gen dut_big (
    .clk (clk),
    .rst (rst),
    .vga (big_if)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .vga (small_if)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  passes = 0;
  int  k = 0;          // clk edges since reset release
  bit  rst_on = 1'b1;
  int  prev_fs_k = -1;
  int  bright_adv = 0;
  int  vs_adv = 0;
  int  frames_checked = 0;

  // Raster position is simply (advances mod line) and (advances / line mod frame).
  function automatic vga_t expect_vga(int kk, bit in_rst, int hv, int hf, int hs, int hb,
                                      int vv, int vf, int vs, int vb);
    vga_t e;
    int n, ht, vt, h, v;
    e = '0;
    if (in_rst || kk == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1; e.b = 1'b1;
      return e;
    end
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    n  = kk / 2;
    h  = n % ht;
    v  = (n / ht) % vt;
    e.en = ((kk % 2) == 1);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = !((h >= hv + hf) && (h < hv + hf + hs));
    e.vs = !((v >= vv + vf) && (v < vv + vf + vs));
    e.hb = (h < hv);
    e.vb = (v < vv);
    e.b  = e.hb && e.vb;
    e.ls = ((kk % 2) == 0) && (n > 0) && (h == 0);
    e.fs = e.ls && (v == 0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_inst(string name, vga_t o, vga_t e);
    chk({name, ".vga_clk_enable"}, 32'(o.en), 32'(e.en));
    chk({name, ".hcount"},         32'(o.h),  32'(e.h));
    chk({name, ".vcount"},         32'(o.v),  32'(e.v));
    chk({name, ".hsync"},          32'(o.hs), 32'(e.hs));
    chk({name, ".vsync"},          32'(o.vs), 32'(e.vs));
    chk({name, ".hbright"},        32'(o.hb), 32'(e.hb));
    chk({name, ".vbright"},        32'(o.vb), 32'(e.vb));
    chk({name, ".bright"},         32'(o.b),  32'(e.b));
    chk({name, ".frame_start"},    32'(o.fs), 32'(e.fs));
    chk({name, ".line_start"},     32'(o.ls), 32'(e.ls));
  endtask

  task automatic check_all();
    vga_t ob, os;
    ob = {big_if.vga_clk_enable, big_if.hcount, big_if.vcount, big_if.hsync, big_if.vsync,
          big_if.hbright, big_if.vbright, big_if.bright, big_if.frame_start, big_if.line_start};
    os = {small_if.vga_clk_enable, small_if.hcount, small_if.vcount, small_if.hsync,
          small_if.vsync, small_if.hbright, small_if.vbright, small_if.bright,
          small_if.frame_start, small_if.line_start};
    check_inst("big", ob, expect_vga(k, rst_on, 640, 16, 96, 48, 480, 10, 2, 29));
    check_inst("small", os, expect_vga(k, rst_on, SH_V, SH_F, SH_S, SH_B,
                                       SV_V, SV_F, SV_S, SV_B));
  endtask

  // One clk edge; sample 1 ns later, then gather whole-frame statistics on the small raster.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_on) k++;
    check_all();
    if (!rst_on && (k % 2) == 0) begin
      if (small_if.frame_start === 1'b1) begin
        if (prev_fs_k >= 0) begin
          chk("frame_period_clks", 32'(k - prev_fs_k), 32'(2 * S_HT * S_VT));
          chk("frame_bright_advances", 32'(bright_adv), 32'(SH_V * SV_V));
          chk("frame_vsync_low_advances", 32'(vs_adv), 32'(SV_S * S_HT));
          frames_checked++;
        end
        chk("fs_with_line_start", 32'(small_if.line_start), 32'd1);
        chk("fs_at_origin", {12'd0, small_if.hcount, small_if.vcount}, 32'd0);
        prev_fs_k  = k;
        bright_adv = 0;
        vs_adv     = 0;
      end
      if (small_if.bright === 1'b1) bright_adv++;
      if (small_if.vsync === 1'b0) vs_adv++;
    end
  endtask

  task automatic wait_big_h(int target);
    int budget;
    budget = 0;
    while (big_if.hcount !== 10'(target) && budget < 4000) begin
      step();
      budget++;
    end
    chk($sformatf("reach_hcount_%0d", target), 32'(big_if.hcount), 32'(target));
  endtask

  // Assert reset between edges, confirm reset values before the next edge, then release.
  task automatic async_reset(int hold);
    #2;
    rst = 1'b1;
    rst_on = 1'b1;
    k = 0;
    prev_fs_k = -1;
    #1;
    check_all();
    chk("async_rst_en_low", 32'(big_if.vga_clk_enable), 32'd0);
    repeat (hold) step();
    rst = 1'b0;
    rst_on = 1'b0;
  endtask

  initial begin
    int hseq [4];
    hseq = '{0, 1, 1, 2};

    rst = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    check_all();
    repeat (2) step();
    rst = 1'b0;
    rst_on = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("release_en_%0d", i), 32'(big_if.vga_clk_enable), 32'(i % 2));
      chk($sformatf("release_h_%0d", i), 32'(big_if.hcount), 32'(hseq[i-1]));
    end

    wait_big_h(639);
    chk("bright_at_639", 32'(big_if.bright), 32'd1);
    wait_big_h(640);
    chk("hbright_fall_640", 32'(big_if.hbright), 32'd0);
    chk("bright_fall_640", 32'(big_if.bright), 32'd0);
    wait_big_h(655);
    chk("hsync_high_655", 32'(big_if.hsync), 32'd1);
    wait_big_h(656);
    chk("hsync_fall_656", 32'(big_if.hsync), 32'd0);
    wait_big_h(751);
    chk("hsync_low_751", 32'(big_if.hsync), 32'd0);
    wait_big_h(752);
    chk("hsync_rise_752", 32'(big_if.hsync), 32'd1);

    repeat (1200) step();
    chk("frame_checks_ran", 32'(frames_checked >= 3), 32'd1);

    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(10, 900)) step();
      async_reset(int'($urandom_range(1, 3)));
    end
    repeat (900) step();
    chk("frame_checks_after_resets", 32'(frames_checked >= 5), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001 SHALL provide parameter H_VISIBLE, default 640, visible pixels per line.
- REQ-002 SHALL provide parameter H_FRONT, default 16, horizontal front-porch pixels.
- REQ-003 SHALL provide parameter H_SYNC, default 96, hsync pulse pixels.
- REQ-004 SHALL provide parameter H_BACK, default 48, horizontal back-porch pixels; line total = 800.
- REQ-005 SHALL provide parameter V_VISIBLE, default 480, visible lines per frame.
- REQ-006 SHALL provide parameter V_FRONT, default 10, vertical front-porch lines.
- REQ-007 SHALL provide parameter V_SYNC, default 2, vsync pulse lines.
- REQ-008 SHALL provide parameter V_BACK, default 29, vertical back-porch lines; frame total = 521.
- REQ-009 SHALL have port: clk  input  1  system clock (50 MHz); one clock; reset is asynchronous and active-high.
- REQ-010 SHALL have port: rst  input  1  asynchronous, active-high reset.
- REQ-011 SHALL have port: vga_clk_enable  output  1  pixel-rate strobe, high every second clk.
- REQ-012 SHALL have port: hcount  output  10  current pixel column, 0..799.
- REQ-013 SHALL have port: vcount  output  10  current line, 0..520.
- REQ-014 SHALL have port: hsync  output  1  horizontal sync, active-low.
- REQ-015 SHALL have port: vsync  output  1  vertical sync, active-low.
- REQ-016 SHALL have port: hbright  output  1  high while hcount < H_VISIBLE.
- REQ-017 SHALL have port: vbright  output  1  high while vcount < V_VISIBLE.
- REQ-018 SHALL have port: bright  output  1  hbright AND vbright.
- REQ-019 SHALL have port: frame_start  output  1  one-clk pulse on wrap to (0,0).
- REQ-020 SHALL have port: line_start  output  1  one-clk pulse on every hcount wrap to 0.

Function
- REQ-021 SHALL toggle vga_clk_enable every clk rising edge; 1-clk-high / 1-clk-low pattern.
- REQ-022 SHALL advance counters only on clk edges where vga_clk_enable is 1; otherwise hold all counter-derived outputs.
- REQ-023 SHALL increment hcount by 1 per advance; at hcount = 799 wrap to 0 and advance vcount.
- REQ-024 SHALL wrap vcount from 520 to 0 on the same advance as hcount 799 -> 0.
- REQ-025 SHALL register hsync, vsync, hbright, vbright, bright from next-counter values so they change on the same edge as hcount/vcount (zero cycles skew relative to counters).
- REQ-026 SHALL drive hsync = 0 iff 656 <= hcount <= 751.
- REQ-027 SHALL drive vsync = 0 iff 490 <= vcount <= 491.
- REQ-028 SHALL assert line_start for exactly one clk, same edge hcount becomes 0; frame_start likewise when hcount and vcount both become 0.
- REQ-029 SHALL never present hcount > 799 or vcount > 520; any out-of-range value SHALL wrap to 0 on the next advance.
- REQ-030 SHALL derive all thresholds from parameters; counter width fixed at 10 bits.

Reset
- REQ-031 SHALL, while rst = 1, force vga_clk_enable = 0, hcount = 0, vcount = 0, hsync = 1, vsync = 1, hbright = 1, vbright = 1, bright = 1, frame_start = 0, line_start = 0, independent of clk.
- REQ-032 SHALL, on rst release, raise vga_clk_enable on the first clk edge; first counter advance (hcount 0 -> 1) on the second clk edge.
- REQ-033 SHALL, on rst asserted mid-frame, return immediately to REQ-031 values, discarding the partial frame.

Verification
- REQ-034 Reset release then 4 clks -> vga_clk_enable sequence 1,0,1,0; hcount sequence 0,1,1,2.
- REQ-035 Run to hcount = 639 -> 640 -> hbright and bright fall on that edge; hcount 655 -> 656 hsync falls; 751 -> 752 hsync rises.
- REQ-036 Run to (799, 520) -> next advance gives (0,0), frame_start = 1 for one clk, line_start = 1 same clk.
- REQ-037 Full frame -> exactly 800 x 521 = 416800 advances (833600 clks) between frame_start pulses; 307200 advances with bright = 1.
- REQ-038 vcount 489 -> 490 -> vsync = 0 for exactly 1600 advances, rises at vcount 492.
- REQ-039 Assert rst asynchronously at (300, 200) between clk edges -> all outputs at REQ-031 values before next clk edge.
